// File: rtl/core_periph_bridge.sv
// -----------------------------------------------------------------------------
// core_periph_bridge
//
// Turns the core's level-held data-peripheral access (d_valid held until
// d_ready) into a registered request/acknowledge transaction on the
// peripheral bus. The bridge holds d_ready low until the bus completes, which
// stalls the core pipeline. It then returns read data and the error status.
//
// Optional feature macro: PERIPH_TIMEOUT_EN
//   When defined, a REQ phase that sees no p_ack for TIMEOUT_CYCLES cycles is
//   force-completed with rdata = all ones and d_err = 1. When undefined, no
//   counter is built and REQ waits for p_ack indefinitely.
//
// Ports:
//   clock, reset        core clock; asynchronous active-high reset
//   d_valid             core access request, held high until d_ready
//   mem_read/mem_write  access type (write wins if both are set)
//   addr, wdata,byte_en core address, store data, store byte enables
//   d_ready             one-cycle completion pulse
//   rdata, d_err        load data / error flag, valid with d_ready
//   p_req, p_we         bus request / write strobe
//   p_addr              addr - PERIPHERAL_BASE, low P_ADDR_WIDTH bits
//   p_wdata, p_be       bus write data / byte enables
//   p_ack, p_rdata,p_err bus completion, read data, error
// -----------------------------------------------------------------------------
module core_periph_bridge #(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int          P_ADDR_WIDTH    = 32,
    parameter int          TIMEOUT_CYCLES  = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    d_valid,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [63:0]             addr,
    input  logic [63:0]             wdata,
    input  logic [7:0]              byte_en,
    output logic                    d_ready,
    output logic [63:0]             rdata,
    output logic                    d_err,
    output logic                    p_req,
    output logic                    p_we,
    output logic [P_ADDR_WIDTH-1:0] p_addr,
    output logic [63:0]             p_wdata,
    output logic [7:0]              p_be,
    input  logic                    p_ack,
    input  logic [63:0]             p_rdata,
    input  logic                    p_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state_q,   state_d;
    logic                    d_ready_q, d_ready_d;
    logic [63:0]             rdata_q,   rdata_d;
    logic                    d_err_q,   d_err_d;
    logic                    p_req_q,   p_req_d;
    logic                    p_we_q,    p_we_d;
    logic [P_ADDR_WIDTH-1:0] p_addr_q,  p_addr_d;
    logic [63:0]             p_wdata_q, p_wdata_d;
    logic [7:0]              p_be_q,    p_be_d;

    // Bus offset: unsigned 64-bit subtraction, truncated to the bus width.
    logic [P_ADDR_WIDTH-1:0] offset;
    assign offset = P_ADDR_WIDTH'(addr - PERIPHERAL_BASE);

    // A load is implied by !mem_write, so mem_read itself carries no extra
    // information here.
    logic unused_ok;

`ifdef PERIPH_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Cleared while idle so it starts at zero on REQ entry; counts REQ cycles
    // that did not see p_ack.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (state_q == REQ && !p_ack) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign unused_ok = mem_read;
`else
    assign unused_ok = mem_read ^ (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        d_err_d   = d_err_q;
        p_we_d    = p_we_q;
        p_addr_d  = p_addr_q;
        p_wdata_d = p_wdata_q;
        p_be_d    = p_be_q;

        case (state_q)
            IDLE: begin
                if (d_valid) begin
                    p_addr_d  = offset;
                    p_wdata_d = wdata;
                    p_be_d    = byte_en;
                    p_we_d    = mem_write;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // p_ack takes priority over a timeout in the same cycle.
                if (p_ack) begin
                    rdata_d = p_we_q ? 64'd0 : p_rdata;
                    d_err_d = p_err;
                    state_d = DONE;
                end
`ifdef PERIPH_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_LAST) begin
                    rdata_d = '1;
                    d_err_d = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are decoded from the next state so they appear
        // as plain flops: no combinational path from p_ack to d_ready.
        d_ready_d = (state_d == DONE);
        p_req_d   = (state_d == REQ);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            d_ready_q <= 1'b0;
            rdata_q   <= '0;
            d_err_q   <= 1'b0;
            p_req_q   <= 1'b0;
            p_we_q    <= 1'b0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            p_be_q    <= '0;
        end else begin
            state_q   <= state_d;
            d_ready_q <= d_ready_d;
            rdata_q   <= rdata_d;
            d_err_q   <= d_err_d;
            p_req_q   <= p_req_d;
            p_we_q    <= p_we_d;
            p_addr_q  <= p_addr_d;
            p_wdata_q <= p_wdata_d;
            p_be_q    <= p_be_d;
        end
    end

    assign d_ready = d_ready_q;
    assign rdata   = rdata_q;
    assign d_err   = d_err_q;
    assign p_req   = p_req_q;
    assign p_we    = p_we_q;
    assign p_addr  = p_addr_q;
    assign p_wdata = p_wdata_q;
    assign p_be    = p_be_q;

endmodule

// File: tb/tb_core_periph_bridge.sv
// -----------------------------------------------------------------------------
// tb_core_periph_bridge
//
// Directed bench for core_periph_bridge. Each scenario task drives the core
// and a hand-scripted bus slave cycle by cycle and compares outputs against
// hand-computed values. The timeout scenario runs only when the bridge is
// built with PERIPH_TIMEOUT_EN (TIMEOUT_CYCLES = 8 here).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_core_periph_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_valid, mem_read, mem_write;
    logic [63:0] addr, wdata;
    logic [7:0]  byte_en;
    logic        d_ready;
    logic [63:0] rdata;
    logic        d_err;
    logic        p_req, p_we;
    logic [31:0] p_addr;
    logic [63:0] p_wdata;
    logic [7:0]  p_be;
    logic        p_ack;
    logic [63:0] p_rdata;
    logic        p_err;

    int checks = 0;
    int errors = 0;

    core_periph_bridge #(
        .PERIPHERAL_BASE (64'h2000_0000),
        .P_ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .d_valid   (d_valid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .byte_en   (byte_en),
        .d_ready   (d_ready),
        .rdata     (rdata),
        .d_err     (d_err),
        .p_req     (p_req),
        .p_we      (p_we),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_be      (p_be),
        .p_ack     (p_ack),
        .p_rdata   (p_rdata),
        .p_err     (p_err)
    );

    always #5 clock = ~clock;

    // Advance to 1 ns after the next rising edge (drive and sample point).
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; d_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0; byte_en = '0;
        p_ack = 1'b0; p_rdata = '0; p_err = 1'b0;
        step(); step();
        checks++;
        if ({d_ready, d_err, p_req, p_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {d_ready, d_err, p_req, p_we});
        end
        checks++;
        if (rdata !== 64'd0 || p_addr !== 32'd0 || p_wdata !== 64'd0 || p_be !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h p_addr=%h p_wdata=%h p_be=%h expected all 0",
                     rdata, p_addr, p_wdata, p_be);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        d_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 64'h2000_0010;
        step();                                   // REQ cycle 1
        checks++;
        if (p_req !== 1'b1 || p_addr !== 32'h10 || p_we !== 1'b0) begin
            errors++;
            $display("FAIL read_req: p_req=%b p_addr=%h p_we=%b expected 1 00000010 0",
                     p_req, p_addr, p_we);
        end
        addr = 64'h2000_0FF0;                     // bus fields must not follow the core
        step();                                   // REQ cycle 2
        checks++;
        if (p_req !== 1'b1 || d_ready !== 1'b0 || p_addr !== 32'h10) begin
            errors++;
            $display("FAIL read_hold: p_req=%b d_ready=%b p_addr=%h expected 1 0 00000010",
                     p_req, d_ready, p_addr);
        end
        step();                                   // REQ cycle 3: slave acks
        p_ack = 1'b1; p_rdata = 64'hDEAD_BEEF; p_err = 1'b0;
        step();                                   // DONE
        p_ack = 1'b0; d_valid = 1'b0; mem_read = 1'b0;
        checks++;
        if (d_ready !== 1'b1 || rdata !== 64'hDEAD_BEEF || d_err !== 1'b0 || p_req !== 1'b0) begin
            errors++;
            $display("FAIL read_done: d_ready=%b rdata=%h d_err=%b p_req=%b expected 1 deadbeef 0 0",
                     d_ready, rdata, d_err, p_req);
        end
        step();                                   // IDLE
        checks++;
        if (d_ready !== 1'b0 || rdata !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_pulse: d_ready=%b rdata=%h expected 0 deadbeef", d_ready, rdata);
        end
    endtask

    task automatic test_single_write();
        d_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b1;   // both set: write wins
        addr = 64'h2000_0008; wdata = 64'h1234; byte_en = 8'h0F;
        p_ack = 1'b1; p_rdata = 64'hAAAA_5555;               // ack in IDLE is ignored
        step();                                              // N+1: REQ, slave acks
        checks++;
        if (p_req !== 1'b1 || p_we !== 1'b1 || p_be !== 8'h0F || p_wdata !== 64'h1234
            || p_addr !== 32'h8 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_req: p_req=%b p_we=%b p_be=%h p_wdata=%h p_addr=%h d_ready=%b expected 1 1 0f 1234 8 0",
                     p_req, p_we, p_be, p_wdata, p_addr, d_ready);
        end
        step();                                              // N+2: DONE
        p_ack = 1'b0; d_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        checks++;
        if (d_ready !== 1'b1 || rdata !== 64'd0 || d_err !== 1'b0) begin
            errors++;
            $display("FAIL write_done: d_ready=%b rdata=%h d_err=%b expected 1 0 0",
                     d_ready, rdata, d_err);
        end
        step();
    endtask

    task automatic test_back_to_back();
        d_valid = 1'b1; mem_read = 1'b1; addr = 64'h2000_0020;
        step();                                   // REQ
        p_ack = 1'b1; p_rdata = 64'd1;
        step();                                   // DONE #1
        p_ack = 1'b0;
        checks++;
        if (d_ready !== 1'b1 || rdata !== 64'd1) begin
            errors++;
            $display("FAIL b2b_first: d_ready=%b rdata=%h expected 1 1", d_ready, rdata);
        end
        step();                                   // IDLE gap, d_valid still high
        checks++;
        if (d_ready !== 1'b0 || p_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: d_ready=%b p_req=%b expected 0 0", d_ready, p_req);
        end
        step();                                   // REQ for the second access
        checks++;
        if (p_req !== 1'b1) begin
            errors++;
            $display("FAIL b2b_req2: p_req=%b expected 1", p_req);
        end
        p_ack = 1'b1; p_rdata = 64'd2;
        step();                                   // DONE #2
        p_ack = 1'b0; d_valid = 1'b0; mem_read = 1'b0;
        checks++;
        if (d_ready !== 1'b1 || rdata !== 64'd2) begin
            errors++;
            $display("FAIL b2b_second: d_ready=%b rdata=%h expected 1 2", d_ready, rdata);
        end
        step();
    endtask

    task automatic test_error();
        d_valid = 1'b1; mem_read = 1'b1; addr = 64'h2000_0030;
        step();
        p_ack = 1'b1; p_err = 1'b1; p_rdata = 64'd5;
        step();                                   // DONE with error
        p_ack = 1'b0; p_err = 1'b0; d_valid = 1'b0;
        checks++;
        if (d_ready !== 1'b1 || d_err !== 1'b1 || rdata !== 64'd5) begin
            errors++;
            $display("FAIL err_done: d_ready=%b d_err=%b rdata=%h expected 1 1 5", d_ready, d_err, rdata);
        end
        step();                                   // IDLE: error flag holds
        checks++;
        if (d_err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: d_err=%b expected 1", d_err);
        end
        d_valid = 1'b1;
        step();
        p_ack = 1'b1; p_rdata = 64'd6;
        step();                                   // clean DONE
        p_ack = 1'b0; d_valid = 1'b0; mem_read = 1'b0;
        checks++;
        if (d_ready !== 1'b1 || d_err !== 1'b0 || rdata !== 64'd6) begin
            errors++;
            $display("FAIL err_clear: d_ready=%b d_err=%b rdata=%h expected 1 0 6", d_ready, d_err, rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_req();
        d_valid = 1'b1; mem_read = 1'b1; addr = 64'h2000_0040;
        step();                                   // REQ
        checks++;
        if (p_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: p_req=%b expected 1", p_req);
        end
        reset = 1'b1;
        #1;                                       // asynchronous: no edge needed
        checks++;
        if (p_req !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: p_req=%b d_ready=%b expected 0 0", p_req, d_ready);
        end
        d_valid = 1'b0; mem_read = 1'b0;
        step();
        reset = 1'b0;
        step();
        checks++;
        if (p_req !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: p_req=%b d_ready=%b expected 0 0", p_req, d_ready);
        end
        d_valid = 1'b1; mem_read = 1'b1; addr = 64'h2000_0044;
        step();
        p_ack = 1'b1; p_rdata = 64'h77;
        step();
        p_ack = 1'b0; d_valid = 1'b0; mem_read = 1'b0;
        checks++;
        if (d_ready !== 1'b1 || rdata !== 64'h77 || p_addr !== 32'h44) begin
            errors++;
            $display("FAIL rst_after: d_ready=%b rdata=%h p_addr=%h expected 1 77 44",
                     d_ready, rdata, p_addr);
        end
        step();
    endtask

`ifdef PERIPH_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        early = 0;
        d_valid = 1'b1; mem_read = 1'b1; addr = 64'h2000_0050;
        step();                                   // REQ entry (count 0)
        for (int i = 0; i < 7; i++) begin
            if (d_ready !== 1'b0 || p_req !== 1'b1) early++;
            step();
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL tmo_wait: %0d early completions, expected 0", early);
        end
        step();                                   // 8 cycles after REQ entry
        d_valid = 1'b0; mem_read = 1'b0;
        p_ack = 1'b1; p_rdata = 64'h1;            // stray ack after timeout
        checks++;
        if (d_ready !== 1'b1 || rdata !== 64'hFFFF_FFFF_FFFF_FFFF || d_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_done: d_ready=%b rdata=%h d_err=%b expected 1 ffffffffffffffff 1",
                     d_ready, rdata, d_err);
        end
        step();
        step();
        p_ack = 1'b0;
        checks++;
        if (d_ready !== 1'b0 || p_req !== 1'b0 || rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL tmo_stray: d_ready=%b p_req=%b rdata=%h expected 0 0 ffffffffffffffff",
                     d_ready, p_req, rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_error();
        test_reset_mid_req();
`ifdef PERIPH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_periph_bridge.md
Name: core_periph_bridge

Overview:
- Downstream consumer of the core's data-peripheral request (`d_valid`) and producer of its completion (`d_ready`).
- Converts the core's level-held peripheral access into a registered request/acknowledge transaction on the peripheral bus.
- Returns read data, and holds `d_ready` low until the access completes, which stalls the pipeline.
- Sits between the core MEM stage and the peripheral interconnect; addresses at or above PERIPHERAL_BASE are routed here.

Parameters:
- PERIPHERAL_BASE, 64'h2000_0000, base subtracted from the core address to form the bus offset.
- P_ADDR_WIDTH, 32, width of the peripheral bus offset.
- TIMEOUT_CYCLES, 256, cycles in REQ without `p_ack` before a forced error completion (only with PERIPH_TIMEOUT_EN).

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- d_valid  in  1  core peripheral access request; held high until d_ready
- mem_read  in  1  access is a load
- mem_write  in  1  access is a store
- addr  in  64  core byte address
- wdata  in  64  store data
- byte_en  in  8  store byte enables
- d_ready  out  1  access complete; one-cycle pulse
- rdata  out  64  load data; valid when d_ready
- d_err  out  1  bus error or timeout; valid when d_ready
- p_req  out  1  bus request
- p_we  out  1  bus write
- p_addr  out  P_ADDR_WIDTH  addr minus PERIPHERAL_BASE, truncated
- p_wdata  out  64  bus write data
- p_be  out  8  bus byte enables
- p_ack  in  1  bus completion
- p_rdata  in  64  bus read data; valid with p_ack
- p_err  in  1  bus error; valid with p_ack

Behaviour:
- Clock is `clock`, sampled on its rising edge. Reset `reset` is asynchronous and active-high.
- Reset state: IDLE. All outputs 0, including d_ready, rdata, d_err, p_req, p_we, p_addr, p_wdata and p_be.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If d_valid is high, latch p_addr, p_wdata and p_be from the core inputs, set p_we = mem_write, and go to REQ.
  - If mem_read and mem_write are both high, treat the access as a write.
- REQ:
  - p_req = 1.
  - Bus fields are held stable while in REQ.
  - On p_ack: rdata ← p_rdata for reads (0 for writes), d_err ← p_err, go to DONE.
- DONE:
  - d_ready = 1 for exactly one cycle; p_req = 0.
  - rdata and d_err hold until the next DONE.
  - Then return to IDLE unconditionally.
- Minimum latency: d_valid sampled at cycle N → p_req high from N+1 → p_ack at N+1 → d_ready at N+2.
- Back-to-back accesses: d_valid still high in the IDLE cycle after DONE is treated as a new access, because the pipeline advanced on d_ready.
- Registered outputs: d_ready, rdata and d_err are registers, with no combinational path from p_ack to d_ready.
- p_ack outside REQ is ignored.
- d_valid deasserting during REQ: the bus transaction still completes (no abort), and d_ready still pulses.
- Reset mid-transaction: immediate return to IDLE with p_req = 0. The bus slave must tolerate the dropped request.
- Address arithmetic: unsigned 64-bit subtraction, low P_ADDR_WIDTH bits kept.

Optional Feature:
- Macro: PERIPH_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on REQ entry and increments each REQ cycle without p_ack.
  - If the count reaches TIMEOUT_CYCLES-1 with no p_ack, the next state is DONE with rdata = 64'hFFFF_FFFF_FFFF_FFFF and d_err = 1.
  - p_ack in that same cycle takes priority over the timeout.
- Without the macro: no counter is built, and REQ waits for p_ack indefinitely.

Test Plan:
- Single read: reset, then d_valid = 1, mem_read = 1, addr = 64'h2000_0010; slave acks after 3 REQ cycles with p_rdata = 64'hDEAD_BEEF → p_addr = 32'h10, p_we = 0, d_ready is a single pulse, rdata = 64'hDEAD_BEEF, d_err = 0.
- Single write: addr = 64'h2000_0008, wdata = 64'h1234, byte_en = 8'h0F, slave acks on the first REQ cycle → p_we = 1, p_be = 8'h0F, p_wdata = 64'h1234, d_ready at N+2, rdata = 0.
- Back-to-back: two reads, d_valid held across them, slave returns 1 then 2 → two distinct d_ready pulses separated by one IDLE cycle; rdata = 1, then 2.
- Error: p_ack with p_err = 1 → d_ready with d_err = 1; the next clean access gives d_err = 0.
- Reset mid-REQ: assert reset for 1 cycle during REQ → p_req = 0 and d_ready = 0 immediately; a later access completes normally.
- PERIPH_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and a slave that never acks → d_ready 8 cycles after REQ entry, rdata = all ones, d_err = 1; a stray p_ack afterwards is ignored.
